// File: rtl/stream_bus_frontend.sv
// Bridge from a request/response bus port to the FT232H command/response byte FIFOs.
// Serialises commands, reassembles responses, aborts stalled responses and drains stray bytes.
module stream_bus_frontend #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              c_full,
  output logic              c_wr_en,
  output logic [7:0]        c_din,
  input  logic              r_empty,
  output logic              r_rd_en,
  input  logic [7:0]        r_dout,
  output logic [7:0]        stray_cnt
);
  localparam int A    = ADDR_W / 8;
  localparam int D    = DATA_W / 8;
  localparam int MAXB = (A > D) ? A : D;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_WDATA, S_RDATA, S_STATUS, S_RESP
  } state_t;

  state_t            state_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [CW-1:0]     byte_cnt_reg;
  logic [CW-1:0]     cap_lane_reg;
  logic              cap_pend_reg;
  logic [TW-1:0]     to_cnt_reg;
  logic              stray_pend_reg;
  logic [7:0]        stray_cnt_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_data_reg;

  logic [7:0] addr_byte  [A];
  logic [7:0] wdata_byte [D];

  genvar gi;
  generate
    for (gi = 0; gi < A; gi++) begin : g_addr_byte
      assign addr_byte[gi] = addr_reg[gi*8 +: 8];
    end
    for (gi = 0; gi < D; gi++) begin : g_wdata_byte
      assign wdata_byte[gi] = wdata_reg[gi*8 +: 8];
    end
  endgenerate

  logic          cmd_state;
  logic          rsp_state;
  logic          issue_ok;
  logic          drain;
  logic          last_cap;
  logic          abort;
  logic [CW-1:0] cmd_last_idx;
  logic [CW-1:0] rsp_need;
  logic [CW-1:0] rsp_last_idx;

  always_comb begin
    cmd_last_idx = '0;
    rsp_need     = '0;
    rsp_last_idx = '0;
    c_din        = 8'h00;
    case (state_reg)
      S_HDR:   c_din = write_reg ? 8'h02 : 8'h01;
      S_ADDR: begin
        cmd_last_idx = CW'(A - 1);
        for (int i = 0; i < A; i++)
          if (byte_cnt_reg == CW'(i)) c_din = addr_byte[i];
      end
      S_WDATA: begin
        cmd_last_idx = CW'(D - 1);
        for (int i = 0; i < D; i++)
          if (byte_cnt_reg == CW'(i)) c_din = wdata_byte[i];
      end
      S_RDATA: begin
        rsp_need     = CW'(D);
        rsp_last_idx = CW'(D - 1);
      end
      S_STATUS: rsp_need = CW'(1);
      default: ;
    endcase
  end

  assign cmd_state = (state_reg == S_HDR) || (state_reg == S_ADDR) || (state_reg == S_WDATA);
  assign rsp_state = (state_reg == S_RDATA) || (state_reg == S_STATUS);
  // A capture landing in the expiry cycle wins, so abort only fires with nothing in flight.
  assign abort     = rsp_state && (TIMEOUT > 0) && !cap_pend_reg && (to_cnt_reg == TO_LAST);
  assign issue_ok  = rsp_state && !r_empty && (byte_cnt_reg < rsp_need) && !abort;
  assign drain     = (state_reg == S_IDLE) && !r_empty;
  assign last_cap  = rsp_state && cap_pend_reg && (cap_lane_reg == rsp_last_idx);

  assign req_ready = (state_reg == S_IDLE) && r_empty;
  assign c_wr_en   = rst_n && cmd_state && !c_full;
  assign r_rd_en   = rst_n && (issue_ok || drain);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;
  assign stray_cnt = stray_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      byte_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            write_reg    <= req_write;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            rdata_reg    <= '0;
            byte_cnt_reg <= '0;
            state_reg    <= S_HDR;
          end
        end
        S_HDR, S_ADDR, S_WDATA: begin
          if (!c_full) begin
            if (byte_cnt_reg == cmd_last_idx) begin
              byte_cnt_reg <= '0;
              case (state_reg)
                S_HDR:   state_reg <= S_ADDR;
                S_ADDR:  state_reg <= write_reg ? S_WDATA : S_RDATA;
                default: state_reg <= S_STATUS;
              endcase
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
        S_RDATA, S_STATUS: begin
          if (cap_pend_reg && (state_reg == S_RDATA)) begin
            for (int i = 0; i < D; i++)
              if (cap_lane_reg == CW'(i)) rdata_reg[i*8 +: 8] <= r_dout;
          end
          if (last_cap) begin
            byte_cnt_reg <= '0;
            if (state_reg == S_RDATA) begin
              state_reg <= S_STATUS;
            end else begin
              state_reg     <= S_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= (r_dout != 8'h00);
              rsp_data_reg  <= ((r_dout != 8'h00) || write_reg) ? '0 : rdata_reg;
            end
          end else if (abort) begin
            byte_cnt_reg  <= '0;
            state_reg     <= S_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b1;
            rsp_data_reg  <= '0;
          end else if (issue_ok) begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Read-to-capture pipeline, idle timer and stray counter; IDLE reads never set the capture flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend_reg   <= 1'b0;
      cap_lane_reg   <= '0;
      to_cnt_reg     <= '0;
      stray_pend_reg <= 1'b0;
      stray_cnt_reg  <= 8'h00;
    end else begin
      cap_pend_reg   <= issue_ok;
      stray_pend_reg <= drain;
      if (issue_ok) cap_lane_reg <= byte_cnt_reg;
      if (stray_pend_reg && (stray_cnt_reg != 8'hFF)) stray_cnt_reg <= stray_cnt_reg + 8'd1;
      if (!rsp_state || cap_pend_reg) to_cnt_reg <= '0;
      else if (to_cnt_reg != TO_MAX) to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

endmodule
